// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared definitions for the byte-serialising RAM controller.
//   - access size encodings (byte / half / word)
//   - controller state encoding
//   - requester identifiers (MEM stage vs. instruction fetch)
//   - common constants Zero / True / False
//   - byte_total(): number of bus bytes for a given access size
package ram_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b11;

    localparam logic        True  = 1'b1;
    localparam logic        False = 1'b0;
    localparam logic [31:0] Zero  = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic {
        REQ_MEM = 1'b0,
        REQ_IF  = 1'b1
    } req_id_t;

    // Encoding 2'b10 is not a defined size; it is handled as a word.
    function automatic logic [2:0] byte_total(input logic [1:0] size);
        case (size)
            SIZE_B:  byte_total = 3'd1;
            SIZE_H:  byte_total = 3'd2;
            default: byte_total = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_ctrl.sv
// ram_ctrl: serialises MEM-stage loads/stores and instruction fetches onto
// an 8-bit synchronous RAM bus, one byte per cycle, little-endian.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   ram_r_req_i/ram_w_req_i MEM read / write request, held until ram_done_o
//   ram_addr_i              MEM byte address
//   ram_w_data_i            MEM store data, LSB-aligned
//   ram_size_i              00 byte, 01 half, 11 word (10 = word)
//   ram_done_o              one-cycle MEM completion pulse
//   ram_r_data_o            zero-extended load data, valid with ram_done_o
//   if_req_i, if_addr_i     fetch request (always a word) and address
//   if_done_o, if_data_o    one-cycle fetch completion pulse and word
//   mem_din_i               RAM read byte, one cycle after its address
//   mem_dout_o, mem_a_o     RAM write byte and byte address
//   mem_wr_o                RAM write strobe
//
// Handshake: a requester raises its request and holds it until it sees its
// done pulse; the controller samples requests only in IDLE, so a request
// still high during DONE does not start a second transaction, and a request
// dropped after being accepted is still completed.
//
// The internal 'state' signal is the FSM state for checkers to bind to.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_r_req_i,
    input  logic              ram_w_req_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [31:0]       ram_w_data_i,
    input  logic [1:0]        ram_size_i,
    output logic              ram_done_o,
    output logic [31:0]       ram_r_data_o,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic [7:0]        mem_din_i,
    output logic [7:0]        mem_dout_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_wr_o
);

    state_t            state;
    req_id_t           req_id;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;
    logic [31:0]       rbuf_next;
    logic [2:0]        n_bytes;
    logic [2:0]        iss;
    logic [2:0]        cap;
    // issue_d1: an address was put on the bus at the last edge.
    // issue_d2: that address's byte is on mem_din_i now and is captured
    //           at the coming edge.
    logic              issue_d1;
    logic              issue_d2;

    // Current buffer with the incoming RAM byte dropped into lane 'cap'.
    always_comb begin
        rbuf_next = rbuf;
        rbuf_next[8*cap[1:0] +: 8] = mem_din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            req_id       <= REQ_MEM;
            base_addr    <= '0;
            wdata        <= Zero;
            rbuf         <= Zero;
            n_bytes      <= 3'd0;
            iss          <= 3'd0;
            cap          <= 3'd0;
            issue_d1     <= False;
            issue_d2     <= False;
            ram_done_o   <= False;
            ram_r_data_o <= Zero;
            if_done_o    <= False;
            if_data_o    <= Zero;
            mem_dout_o   <= 8'd0;
            mem_a_o      <= '0;
            mem_wr_o     <= False;
        end else begin
            case (state)
                ST_IDLE: begin
                    ram_done_o   <= False;
                    if_done_o    <= False;
                    ram_r_data_o <= Zero;
                    if_data_o    <= Zero;
                    mem_wr_o     <= False;
                    mem_a_o      <= '0;
                    mem_dout_o   <= 8'd0;
                    rbuf         <= Zero;
                    iss          <= 3'd0;
                    cap          <= 3'd0;
                    issue_d1     <= False;
                    issue_d2     <= False;
                    // Priority: MEM write, MEM read, fetch. The first bus
                    // byte is driven straight from the request inputs.
                    if (ram_w_req_i) begin
                        req_id     <= REQ_MEM;
                        base_addr  <= ram_addr_i;
                        wdata      <= ram_w_data_i;
                        n_bytes    <= byte_total(ram_size_i);
                        iss        <= 3'd1;
                        mem_wr_o   <= True;
                        mem_a_o    <= ram_addr_i;
                        mem_dout_o <= ram_w_data_i[7:0];
                        state      <= ST_WR;
                    end else if (ram_r_req_i) begin
                        req_id    <= REQ_MEM;
                        base_addr <= ram_addr_i;
                        n_bytes   <= byte_total(ram_size_i);
                        iss       <= 3'd1;
                        issue_d1  <= True;
                        mem_a_o   <= ram_addr_i;
                        state     <= ST_RD;
                    end else if (if_req_i) begin
                        req_id    <= REQ_IF;
                        base_addr <= if_addr_i;
                        n_bytes   <= byte_total(SIZE_W);
                        iss       <= 3'd1;
                        issue_d1  <= True;
                        mem_a_o   <= if_addr_i;
                        state     <= ST_RD;
                    end
                end

                ST_RD: begin
                    issue_d2 <= issue_d1;
                    if (iss < n_bytes) begin
                        mem_a_o  <= base_addr + ADDR_W'(iss);
                        iss      <= iss + 3'd1;
                        issue_d1 <= True;
                    end else begin
                        mem_a_o  <= '0;
                        issue_d1 <= False;
                    end
                    if (issue_d2) begin
                        rbuf <= rbuf_next;
                        cap  <= cap + 3'd1;
                        if (cap == 3'(n_bytes - 3'd1)) begin
                            state <= ST_DONE;
                            if (req_id == REQ_IF) begin
                                if_done_o <= True;
                                if_data_o <= rbuf_next;
                            end else begin
                                ram_done_o   <= True;
                                ram_r_data_o <= rbuf_next;
                            end
                        end
                    end
                end

                ST_WR: begin
                    if (iss < n_bytes) begin
                        mem_wr_o   <= True;
                        mem_a_o    <= base_addr + ADDR_W'(iss);
                        mem_dout_o <= wdata[8*iss[1:0] +: 8];
                        iss        <= iss + 3'd1;
                    end else begin
                        mem_wr_o   <= False;
                        mem_a_o    <= '0;
                        mem_dout_o <= 8'd0;
                        state      <= ST_DONE;
                        if (req_id == REQ_IF) begin
                            if_done_o <= True;
                        end else begin
                            ram_done_o <= True;
                        end
                    end
                end

                ST_DONE: begin
                    // Requests are deliberately not looked at here.
                    ram_done_o   <= False;
                    if_done_o    <= False;
                    ram_r_data_o <= Zero;
                    if_data_o    <= Zero;
                    state        <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
